// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioning: synchronizes the cadence pulse, measures edges per window,
// and keeps a cadence-gated exponential average of the torque sample.
module pedal_sensor_cond #(
    parameter int WIN_CYCLES     = 2048,
    parameter int NOT_PED_THRESH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cadence,
    input  logic [11:0] torque,
    output logic [4:0]  cadence_vec,
    output logic        vec_vld,
    output logic        not_pedaling,
    output logic [11:0] avg_torque
);

    localparam int               WIN_W    = $clog2(WIN_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [5:0]       THRESH   = 6'(NOT_PED_THRESH);

    function automatic logic [4:0] sat31(input logic [5:0] v);
        logic [4:0] r;
        if (v > 6'd31) begin
            r = 5'd31;
        end else begin
            r = v[4:0];
        end
        return r;
    endfunction

    logic             s1_q, s2_q, s3_q;
    logic             s1_d, s2_d, s3_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [4:0]       edge_cnt_q, edge_cnt_d;
    logic [4:0]       cadence_vec_q, cadence_vec_d;
    logic             vec_vld_q, vec_vld_d;
    logic             not_pedaling_q, not_pedaling_d;
    logic [16:0]      accum_q, accum_d;
    logic             rise_s;
    logic             term_s;
    logic [4:0]       vec_next_s;

    // Next-state logic for synchronizer, window/edge counters, outputs and accumulator
    always_comb begin
        s1_d           = cadence;
        s2_d           = s1_q;
        s3_d           = s2_q;
        rise_s         = s2_q & ~s3_q;
        term_s         = (win_cnt_q == WIN_LAST);
        vec_next_s     = sat31({1'b0, edge_cnt_q} + {5'd0, rise_s});
        win_cnt_d      = win_cnt_q;
        edge_cnt_d     = edge_cnt_q;
        cadence_vec_d  = cadence_vec_q;
        vec_vld_d      = 1'b0;
        not_pedaling_d = not_pedaling_q;
        accum_d        = accum_q;

        if (term_s) begin
            win_cnt_d      = '0;
            edge_cnt_d     = 5'd0;
            cadence_vec_d  = vec_next_s;
            vec_vld_d      = 1'b1;
            not_pedaling_d = ({1'b0, vec_next_s} < THRESH);
        end else begin
            win_cnt_d = win_cnt_q + WIN_ONE;
            if (rise_s && (edge_cnt_q != 5'd31)) begin
                edge_cnt_d = edge_cnt_q + 5'd1;
            end else begin
                edge_cnt_d = edge_cnt_q;
            end
        end

        // Seeding from live torque takes priority over the averaging update
        if (not_pedaling_q) begin
            accum_d = {torque, 5'b0};
        end else if (rise_s) begin
            accum_d = accum_q - {5'd0, accum_q[16:5]} + {5'd0, torque};
        end else begin
            accum_d = accum_q;
        end
    end

    // State registers; synchronizer resets high so a held-high cadence yields no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q           <= 1'b1;
            s2_q           <= 1'b1;
            s3_q           <= 1'b1;
            win_cnt_q      <= '0;
            edge_cnt_q     <= 5'd0;
            cadence_vec_q  <= 5'd0;
            vec_vld_q      <= 1'b0;
            not_pedaling_q <= 1'b1;
            accum_q        <= 17'd0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            win_cnt_q      <= win_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            cadence_vec_q  <= cadence_vec_d;
            vec_vld_q      <= vec_vld_d;
            not_pedaling_q <= not_pedaling_d;
            accum_q        <= accum_d;
        end
    end

    assign cadence_vec  = cadence_vec_q;
    assign vec_vld      = vec_vld_q;
    assign not_pedaling = not_pedaling_q;
    assign avg_torque   = accum_q[16:5];

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Self-checking bench for pedal_sensor_cond: a window scoreboard plus per-scenario checks.
module tb_pedal_sensor_cond;

    localparam int W   = 2048;
    localparam int THR = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cadence;
    logic [11:0] torque;
    logic [4:0]  cadence_vec;
    logic        vec_vld;
    logic        not_pedaling;
    logic [11:0] avg_torque;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ph       = 0;
    logic prev_c   = 1'b1;
    int   exp_q[$];

    always #5 clk = ~clk;

    pedal_sensor_cond #(.WIN_CYCLES(W), .NOT_PED_THRESH(THR)) dut (
        .clk(clk), .rst_n(rst_n), .cadence(cadence), .torque(torque),
        .cadence_vec(cadence_vec), .vec_vld(vec_vld),
        .not_pedaling(not_pedaling), .avg_torque(avg_torque)
    );

    function automatic logic cad_wave(input int p, input int period);
        return ((p % period) >= (period / 2));
    endfunction

    // One clock: check window output from the edge just passed, then drive cadence for the next edge.
    // Each driven rising cadence pushes the window-end edge it must be counted in.
    task automatic tick(input logic c);
        int         n_exp;
        logic       vld_exp;
        logic [4:0] vec_exp;
        @(negedge clk);
        if (!rst_n) begin
            cyc     = 0;
            exp_q.delete();
            cadence = c;
            prev_c  = 1'b1;
        end else begin
            cyc++;
            vld_exp = ((cyc % W) == 0);
            if (vld_exp || vec_vld) begin
                checks++;
                if (vec_vld !== vld_exp) begin
                    failures++;
                    $display("FAIL vec_vld_timing cyc=%0d got=%b exp=%b", cyc, vec_vld, vld_exp);
                end
                if (vld_exp) begin
                    n_exp = 0;
                    while (exp_q.size() > 0 && exp_q[0] == cyc) begin
                        void'(exp_q.pop_front());
                        n_exp++;
                    end
                    vec_exp = (n_exp > 31) ? 5'd31 : 5'(n_exp);
                    checks++;
                    if (cadence_vec !== vec_exp) begin
                        failures++;
                        $display("FAIL sb_cadence_vec cyc=%0d got=%0d exp=%0d", cyc, cadence_vec, vec_exp);
                    end
                    checks++;
                    if (not_pedaling !== (vec_exp < 5'(THR))) begin
                        failures++;
                        $display("FAIL sb_not_pedaling cyc=%0d got=%b exp=%b", cyc, not_pedaling, (vec_exp < 5'(THR)));
                    end
                end
            end
            cadence = c;
            if (!prev_c && c) exp_q.push_back(((cyc + 2) / W + 1) * W);
            prev_c = c;
        end
    endtask

    task automatic run_wave(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            tick(cad_wave(ph, period));
            ph++;
        end
    endtask

    task automatic run_to_boundary(input logic c);
        tick(c);
        for (int i = 0; i < W && (cyc % W) != 0; i++) tick(c);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (cadence_vec !== 5'd0 || vec_vld !== 1'b0 || not_pedaling !== 1'b1 || avg_torque !== 12'd0) begin
            failures++;
            $display("FAIL %s got vec=%0d vld=%b np=%b avg=%h exp vec=0 vld=0 np=1 avg=000",
                     tag, cadence_vec, vec_vld, not_pedaling, avg_torque);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        cadence = 1'b1;
        torque  = 12'h800;
        repeat (3) tick(1'b1);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        tick(1'b1);
        checks++;
        if (avg_torque !== 12'h800) begin
            failures++;
            $display("FAIL reset_seed got=%h exp=800", avg_torque);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.rise_s !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_rise cyc=%0d got=%b exp=0", cyc, dut.rise_s);
            end
            tick(1'b1);
        end
    endtask

    task automatic test_steady();
        run_wave(3 * W, 128);
        checks++;
        if (cadence_vec !== 5'd16 || not_pedaling !== 1'b0) begin
            failures++;
            $display("FAIL steady got vec=%0d np=%b exp vec=16 np=0", cadence_vec, not_pedaling);
        end
    endtask

    task automatic test_saturation();
        run_wave(3 * W, 32);
        checks++;
        if (cadence_vec !== 5'd31) begin
            failures++;
            $display("FAIL saturation got=%0d exp=31", cadence_vec);
        end
        run_to_boundary(1'b0);
        run_to_boundary(1'b0);
        for (int k = 0; k < 15; k++) begin
            repeat (32) tick(1'b1);
            repeat (32) tick(1'b0);
        end
        for (int i = 0; i < W && ((cyc + 1) % W) != (W - 3); i++) tick(1'b0);
        tick(1'b1);
        for (int i = 0; i < 8 && (cyc % W) != 0; i++) tick(1'b1);
        checks++;
        if (cadence_vec !== 5'd16 || vec_vld !== 1'b1) begin
            failures++;
            $display("FAIL terminal_edge got vec=%0d vld=%b exp vec=16 vld=1", cadence_vec, vec_vld);
        end
    endtask

    task automatic test_torque_step();
        logic [11:0] prev_avg;
        bit          seen;
        for (int i = 0; i < 3 * W && not_pedaling !== 1'b1; i++) tick(1'b0);
        tick(1'b0);
        checks++;
        if (not_pedaling !== 1'b1 || avg_torque !== 12'h800) begin
            failures++;
            $display("FAIL torque_seed got np=%b avg=%h exp np=1 avg=800", not_pedaling, avg_torque);
        end
        ph = 0;
        for (int i = 0; i < 3 * W && not_pedaling !== 1'b0; i++) begin
            tick(cad_wave(ph, 128));
            ph++;
        end
        checks++;
        if (not_pedaling !== 1'b0) begin
            failures++;
            $display("FAIL torque_pedal_start got np=%b exp np=0", not_pedaling);
        end
        torque = 12'h360;
        for (int i = 0; i < 300 && avg_torque === 12'h800; i++) begin
            tick(cad_wave(ph, 128));
            ph++;
        end
        checks++;
        if (avg_torque !== 12'h7DB || dut.accum_q !== 17'hFB60) begin
            failures++;
            $display("FAIL torque_step got avg=%h accum=%h exp avg=7db accum=fb60", avg_torque, dut.accum_q);
        end
        for (int k = 0; k < 5; k++) begin
            prev_avg = avg_torque;
            seen     = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                tick(cad_wave(ph, 128));
                ph++;
                if (avg_torque !== prev_avg) seen = 1'b1;
            end
            checks++;
            if (!seen || avg_torque >= prev_avg || avg_torque < 12'h360) begin
                failures++;
                $display("FAIL torque_monotonic got=%h prev=%h exp below prev and >= 360", avg_torque, prev_avg);
            end
        end
    endtask

    task automatic test_stop();
        for (int i = 0; i < W && (cyc % W) != 0; i++) begin
            tick(cad_wave(ph, 128));
            ph++;
        end
        run_to_boundary(1'b0);
        repeat (1000) tick(1'b0);
        repeat (20) tick(1'b1);
        run_to_boundary(1'b0);
        checks++;
        if (cadence_vec !== 5'd1 || not_pedaling !== 1'b1) begin
            failures++;
            $display("FAIL stop got vec=%0d np=%b exp vec=1 np=1", cadence_vec, not_pedaling);
        end
        torque = 12'h7E0;
        tick(1'b0);
        checks++;
        if (avg_torque !== 12'h7E0) begin
            failures++;
            $display("FAIL stop_track_a got=%h exp=7e0", avg_torque);
        end
        torque = 12'h123;
        tick(1'b0);
        checks++;
        if (avg_torque !== 12'h123) begin
            failures++;
            $display("FAIL stop_track_b got=%h exp=123", avg_torque);
        end
    endtask

    task automatic test_mid_reset();
        int wait_cnt;
        run_to_boundary(1'b0);
        ph = 0;
        for (int i = 0; i < W && (cyc % W) != 1000; i++) begin
            tick(cad_wave(ph, 128));
            ph++;
        end
        checks++;
        if (dut.edge_cnt_q !== 5'd8) begin
            failures++;
            $display("FAIL mid_pre_count got=%0d exp=8", dut.edge_cnt_q);
        end
        rst_n = 1'b0;
        repeat (3) tick(1'b0);
        check_reset_outputs("mid_reset_values");
        rst_n    = 1'b1;
        ph       = 0;
        wait_cnt = 0;
        for (int i = 1; i <= 2 * W && wait_cnt == 0; i++) begin
            tick(cad_wave(ph, 128));
            ph++;
            if (vec_vld === 1'b1) wait_cnt = i;
        end
        checks++;
        if (wait_cnt != W || cadence_vec !== 5'd16) begin
            failures++;
            $display("FAIL mid_reset_window got cycles=%0d vec=%0d exp cycles=%0d vec=16", wait_cnt, cadence_vec, W);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        cadence = 1'b1;
        torque  = 12'h800;
        test_reset();
        test_steady();
        test_saturation();
        test_torque_step();
        test_stop();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pedal_sensor_cond.md
# pedal_sensor_cond

Conditions the raw pedal sensors into the rider-effort inputs for the desired-drive stage. It synchronizes the asynchronous cadence pulse and measures cadence as edges-per-window (`cadence_vec`). It also keeps a cadence-gated exponential average of the torque ADC sample (`avg_torque`) and flags when the rider is not pedaling. It sits directly upstream of `desiredDrive`, which consumes `cadence_vec` and `avg_torque`.

## Interface
- `WIN_CYCLES`, 2048: clock cycles per cadence measurement window (≥ 64). Silicon builds override this with a larger value.
- `NOT_PED_THRESH`, 2: `not_pedaling` asserts when `cadence_vec` < this value.
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cadence`  in  1  raw pedal cadence pulse, asynchronous to `clk`
- `torque`  in  12  unsigned torque ADC sample, synchronous to `clk`
- `cadence_vec`  out  5  rising cadence edges counted in the last completed window, saturated at 31
- `vec_vld`  out  1  one-cycle pulse when `cadence_vec` updates
- `not_pedaling`  out  1  registered, 1 when `cadence_vec` < `NOT_PED_THRESH`
- `avg_torque`  out  12  exponentially averaged torque

## Operation
- **Synchronizer:** three flops `s1`→`s2`→`s3`, all reset to 1 so a cadence held high through reset produces no edge. `rise = s2 & ~s3`. Falling edges are ignored.
- **Window counter:** free-running `win_cnt` of width `$clog2(WIN_CYCLES)`, counting 0..`WIN_CYCLES`-1 and wrapping. The terminal cycle is `win_cnt == WIN_CYCLES-1`.
- **Edge counter:** 5-bit `edge_cnt`. It increments on `rise` and saturates at 31, never wrapping.
- **Terminal cycle:**
  - `cadence_vec <= sat31(edge_cnt + rise)`, so an edge in the terminal cycle counts in the closing window.
  - `edge_cnt <= 0`.
  - `vec_vld <= 1` for exactly one cycle.
  - `not_pedaling <= (new cadence_vec < NOT_PED_THRESH)`.
- **Torque accumulator:** 17-bit `accum`, with `avg_torque = accum[16:5]`.
  - If `not_pedaling` = 1, `accum <= {torque, 5'b0}` every cycle, so the average seeds from the live torque.
  - Otherwise, on `rise`, `accum <= accum - (accum >> 5) + torque`, a weight-31/32 exponential average.
  - Otherwise `accum` holds.
- **Arithmetic:** unsigned throughout. The accumulator's steady state for constant `t` is exactly `32·t`, and the worst case 4095·32 = 131040 fits in 17 bits, so no overflow handling is needed.
- **Simultaneous events:**
  - `rise` in the same cycle `not_pedaling` is 1: the seed load wins.
  - `rise` on the same cycle that `not_pedaling` deasserts: the update uses the old `not_pedaling` (1), so it seeds.

## Timing
- **Reset values:** `cadence_vec` = 0, `vec_vld` = 0, `not_pedaling` = 1, `avg_torque` = 0, `accum` = 0, `edge_cnt` = 0, `win_cnt` = 0, `s1`/`s2`/`s3` = 1.
- **Cadence latency:** `cadence` rises and meets setup before clk edge N. `rise` is high between edges N+1 and N+2. `accum` updates at edge N+2, sampling `torque` at that edge.
- **Window latency:** `cadence_vec`, `vec_vld` and `not_pedaling` update at the edge that ends the terminal cycle. The first update occurs at edge `WIN_CYCLES` after reset release.
- **Stability:** `cadence_vec` is stable for `WIN_CYCLES` cycles between updates.
- **Reset mid-window:** all state returns to reset values immediately (asynchronous). The partial window is discarded and the next window starts at `win_cnt` = 0.
- **Fast cadence:** the minimum resolvable cadence high/low time is 2 clocks. Pulses shorter than this may be missed; this is acceptable.

## Test plan
1. **Reset:**
   - Assert `rst_n`=0 with `cadence`=1 and `torque`=0x800.
   - Required: `cadence_vec`=0, `vec_vld`=0, `not_pedaling`=1, `avg_torque`=0.
   - After release: no `rise` pulse, and `avg_torque`=0x800 at the 1st clk edge.
2. **Steady cadence:**
   - Cadence period 128 clocks, 50% duty, `WIN_CYCLES`=2048.
   - Required: every full window yields `cadence_vec`=16 with `vec_vld` pulsed once, and `not_pedaling`=0.
3. **Saturation:**
   - Cadence period 32 clocks (64 edges/window).
   - Required: `cadence_vec`=31 and no wrap.
   - Separately, an edge placed on the terminal cycle with `edge_cnt`=15 yields 16.
4. **Torque seed then step:**
   - Hold `torque`=0x800 while `not_pedaling`=1, so `avg_torque`=0x800.
   - After pedaling is established, step `torque` to 0x360.
   - Required: the next `rise` gives `accum`=0xFB60 and `avg_torque`=0x7DB. `avg_torque` decreases monotonically toward 0x360 on later edges.
5. **Stop pedaling:**
   - Drop to 1 edge per window.
   - Required: the next `vec_vld` shows `cadence_vec`=1 and `not_pedaling`=1, and `avg_torque` then tracks `torque` each cycle (e.g. 0x7E0 → 0x7E0).
6. **Mid-window reset:**
   - Pulse `rst_n` low for 3 clocks at `win_cnt`≈1000 with 8 edges counted.
   - Required: outputs return to reset values, and the next `vec_vld` arrives exactly `WIN_CYCLES` edges after release with a count covering only post-reset edges.
